// File: rtl/axis_shifter_arbiter.sv
// Two-requester arbiter in front of a shared AXI-Stream shifter.
// Tags each issued beat and routes results back in issue order.
module axis_shifter_arbiter #(
  parameter int SHIFT_WIDTH  = 7,
  parameter int INPUT_WIDTH  = 39,
  parameter int OUTPUT_WIDTH = 70,
  parameter int TAG_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SHIFT_WIDTH-1:0]  req0_shift,
  input  logic [INPUT_WIDTH-1:0]  req0_data,
  input  logic                    req0_last,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [SHIFT_WIDTH-1:0]  req1_shift,
  input  logic [INPUT_WIDTH-1:0]  req1_data,
  input  logic                    req1_last,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  output logic [SHIFT_WIDTH-1:0]  sh_shift_data,
  output logic                    sh_shift_valid,
  input  logic                    sh_shift_ready,
  output logic [INPUT_WIDTH-1:0]  sh_input_data,
  output logic                    sh_input_last,
  output logic                    sh_input_valid,
  input  logic                    sh_input_ready,
  input  logic [OUTPUT_WIDTH-1:0] sh_output_data,
  input  logic                    sh_output_valid,
  output logic                    sh_output_ready,
  output logic [OUTPUT_WIDTH-1:0] resp0_data,
  output logic                    resp0_last,
  output logic                    resp0_valid,
  input  logic                    resp0_ready,
  output logic [OUTPUT_WIDTH-1:0] resp1_data,
  output logic                    resp1_last,
  output logic                    resp1_valid,
  input  logic                    resp1_ready
);

  localparam int PW = $clog2(TAG_DEPTH);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e         state_q, state_d;
  logic           own_q, own_d;
  logic           prio_q, prio_d;
  logic           ssent_q, ssent_d;
  logic           isent_q, isent_d;
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [PW:0]    cnt_q;
  logic [1:0]     tag_q [TAG_DEPTH];

  logic full, empty, locked;
  logic own_valid, own_last;
  logic shs, ihs, done, push, pop;
  logic head_own, head_last;

  assign full   = cnt_q == (PW+1)'(TAG_DEPTH);
  assign empty  = cnt_q == '0;
  assign locked = state_q == LOCK;

  assign own_valid = own_q ? req1_valid : req0_valid;
  assign own_last  = own_q ? req1_last  : req0_last;

  assign sh_shift_data  = own_q ? req1_shift : req0_shift;
  assign sh_input_data  = own_q ? req1_data  : req0_data;
  assign sh_input_last  = own_last;
  assign sh_shift_valid = locked & own_valid & ~ssent_q & ~full;
  assign sh_input_valid = locked & own_valid & ~isent_q & ~full;

  assign shs  = sh_shift_valid & sh_shift_ready;
  assign ihs  = sh_input_valid & sh_input_ready;
  assign done = locked & own_valid
              & (ssent_q | shs) & (isent_q | ihs);

  assign req0_ready = done & ~own_q;
  assign req1_ready = done & own_q;

  assign head_own  = tag_q[rptr_q][1];
  assign head_last = tag_q[rptr_q][0];

  assign sh_output_ready = ~empty
                         & (head_own ? resp1_ready : resp0_ready);
  assign resp0_valid = ~empty & ~head_own & sh_output_valid;
  assign resp1_valid = ~empty & head_own & sh_output_valid;
  assign resp0_data  = sh_output_data;
  assign resp1_data  = sh_output_data;
  assign resp0_last  = head_last;
  assign resp1_last  = head_last;

  assign push = done;
  assign pop  = sh_output_valid & sh_output_ready;

  // Grant selection, per-channel sent tracking and packet release.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    prio_d  = prio_q;
    ssent_d = ssent_q;
    isent_d = isent_q;
    unique case (state_q)
      IDLE: begin
        if ((req0_valid | req1_valid) & ~full) begin
          state_d = LOCK;
          own_d   = (req0_valid & req1_valid) ? prio_q : req1_valid;
        end
      end
      LOCK: begin
        if (done) begin
          ssent_d = 1'b0;
          isent_d = 1'b0;
          if (own_last) begin
            state_d = IDLE;
            prio_d  = ~own_q;
          end
        end else begin
          if (shs) ssent_d = 1'b1;
          if (ihs) isent_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      prio_q  <= 1'b0;
      ssent_q <= 1'b0;
      isent_q <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      prio_q  <= prio_d;
      ssent_q <= ssent_d;
      isent_q <= isent_d;
    end
  end

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Tag storage: {owner, last} of each issued beat.
  always_ff @(posedge clk) begin
    if (push) tag_q[wptr_q] <= {own_q, own_last};
  end

endmodule

// File: tb/tb_axis_shifter_arbiter.sv
// Bench for axis_shifter_arbiter: random requesters, shifter model,
// per-requester expected-result queues checked by a monitor.
module tb_axis_shifter_arbiter;

  localparam int SW = 7;
  localparam int IW = 39;
  localparam int OW = 70;
  localparam int TD = 4;

  typedef struct packed {
    logic [SW-1:0] s;
    logic [IW-1:0] d;
    logic          l;
  } beat_t;

  typedef struct packed {
    logic [OW-1:0] r;
    logic          l;
  } exp_t;

  logic          clk, rst;
  logic [SW-1:0] req0_shift, req1_shift;
  logic [IW-1:0] req0_data, req1_data;
  logic          req0_last, req0_valid, req0_ready;
  logic          req1_last, req1_valid, req1_ready;
  logic [SW-1:0] sh_shift_data;
  logic          sh_shift_valid, sh_shift_ready;
  logic [IW-1:0] sh_input_data;
  logic          sh_input_last, sh_input_valid, sh_input_ready;
  logic [OW-1:0] sh_output_data;
  logic          sh_output_valid, sh_output_ready;
  logic [OW-1:0] resp0_data, resp1_data;
  logic          resp0_last, resp0_valid, resp0_ready;
  logic          resp1_last, resp1_valid, resp1_ready;

  axis_shifter_arbiter #(
    .SHIFT_WIDTH(SW), .INPUT_WIDTH(IW),
    .OUTPUT_WIDTH(OW), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_shift(req0_shift), .req0_data(req0_data),
    .req0_last(req0_last), .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req1_shift(req1_shift), .req1_data(req1_data),
    .req1_last(req1_last), .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .sh_shift_data(sh_shift_data), .sh_shift_valid(sh_shift_valid),
    .sh_shift_ready(sh_shift_ready),
    .sh_input_data(sh_input_data), .sh_input_last(sh_input_last),
    .sh_input_valid(sh_input_valid), .sh_input_ready(sh_input_ready),
    .sh_output_data(sh_output_data), .sh_output_valid(sh_output_valid),
    .sh_output_ready(sh_output_ready),
    .resp0_data(resp0_data), .resp0_last(resp0_last),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_data(resp1_data), .resp1_last(resp1_last),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  beat_t         src0[$], src1[$];
  exp_t          exp0[$], exp1[$];
  logic [SW-1:0] shq[$];
  logic [IW-1:0] inq[$];
  logic [OW-1:0] outq[$];
  logic [IW-1:0] log_in[$];

  bit go0, go1, ovh;
  int pct_reqv = 100, pct_shr = 100, pct_inr = 100;
  int pct_outv = 100, pct_r0 = 100, pct_r1 = 100;
  int n_shhs = 0, n_inhs = 0, n_r1 = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit rnd(int pct);
    return $urandom_range(99) < pct;
  endfunction

  // Reference result: operand zero-extended then shifted left.
  function automatic logic [OW-1:0] shl(logic [IW-1:0] d,
                                        logic [SW-1:0] s);
    logic [OW-1:0] x;
    x = OW'(d);
    if (int'(s) >= OW) return '0;
    for (int i = 0; i < int'(s); i++) x = x * 2;
    return x;
  endfunction

  function automatic logic [6:0] outs();
    return {req0_ready, req1_ready, sh_shift_valid, sh_input_valid,
            sh_output_ready, resp0_valid, resp1_valid};
  endfunction

  task automatic clear_all();
    src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
    shq.delete(); inq.delete(); outq.delete();
    go0 = 0; go1 = 0; ovh = 0;
  endtask

  task automatic drive();
    beat_t b;
    if (!go0 && src0.size() > 0 && rnd(pct_reqv)) go0 = 1;
    if (!go1 && src1.size() > 0 && rnd(pct_reqv)) go1 = 1;
    b = (src0.size() > 0) ? src0[0] : '0;
    req0_valid = go0; req0_shift = b.s;
    req0_data = b.d; req0_last = b.l;
    b = (src1.size() > 0) ? src1[0] : '0;
    req1_valid = go1; req1_shift = b.s;
    req1_data = b.d; req1_last = b.l;
    sh_shift_ready = rnd(pct_shr);
    sh_input_ready = rnd(pct_inr);
    if (!ovh && outq.size() > 0 && rnd(pct_outv)) ovh = 1;
    sh_output_valid = ovh;
    sh_output_data  = (outq.size() > 0) ? outq[0] : '0;
    resp0_ready = rnd(pct_r0);
    resp1_ready = rnd(pct_r1);
  endtask

  // Books the transfers that the coming rising edge will perform.
  task automatic book();
    if (req0_valid && req0_ready) begin
      exp0.push_back({shl(src0[0].d, src0[0].s), src0[0].l});
      void'(src0.pop_front()); go0 = 0;
    end
    if (req1_valid && req1_ready) begin
      exp1.push_back({shl(src1[0].d, src1[0].s), src1[0].l});
      void'(src1.pop_front()); go1 = 0;
    end
    if (sh_shift_valid && sh_shift_ready) begin
      shq.push_back(sh_shift_data); n_shhs++;
    end
    if (sh_input_valid && sh_input_ready) begin
      inq.push_back(sh_input_data); log_in.push_back(sh_input_data);
      n_inhs++;
    end
    if (sh_output_valid && sh_output_ready) begin
      void'(outq.pop_front()); ovh = 0;
    end
    while (shq.size() > 0 && inq.size() > 0)
      outq.push_back(shl(inq.pop_front(), shq.pop_front()));
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1;
    book();
  endtask

  task automatic apply_reset(int cycles);
    @(negedge clk);
    rst = 1'b0;
    clear_all();
    req0_valid = 1; req1_valid = 1; sh_shift_ready = 1;
    sh_input_ready = 1; sh_output_valid = 1;
    resp0_ready = 1; resp1_ready = 1;
    #1;
    chk("reset_outs", outs(), 7'd0);
    repeat (cycles) @(negedge clk);
    chk("reset_hold_outs", outs(), 7'd0);
    req0_valid = 0; req1_valid = 0; sh_output_valid = 0;
    rst = 1'b1;
  endtask

  task automatic drain(int budget);
    int k;
    k = 0;
    while ((src0.size() + src1.size() + exp0.size() + exp1.size()
            + outq.size()) != 0 && k < budget) begin
      step();
      k++;
    end
    chk("drain_timeout", k >= budget, 1'b0);
  endtask

  // Monitor: routed results against per-requester expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        chk("resp_onehot", resp0_valid & resp1_valid, 1'b0);
        if (exp0.size() == 0) chk("resp0_spurious", resp0_valid, 1'b0);
        if (exp1.size() == 0) chk("resp1_spurious", resp1_valid, 1'b0);
        if (resp0_valid && resp0_ready && exp0.size() > 0) begin
          e = exp0.pop_front();
          chk("resp0_beat", {resp0_data, resp0_last}, e);
        end
        if (resp1_valid && resp1_ready && exp1.size() > 0) begin
          e = exp1.pop_front();
          chk("resp1_beat", {resp1_data, resp1_last}, e);
          n_r1++;
        end
      end
    end
  end

  initial begin
    int b;
    rst = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_last = 0; req1_last = 0;
    req0_shift = '0; req1_shift = '0; req0_data = '0; req1_data = '0;
    sh_shift_ready = 0; sh_input_ready = 0; sh_output_valid = 0;
    sh_output_data = '0; resp0_ready = 0; resp1_ready = 0;
    apply_reset(3);

    // Single beat, registered grant.
    src0.push_back('{3, 1, 1});
    step();
    chk("grant_registered", {sh_shift_valid, sh_input_valid}, 2'b00);
    step();
    chk("issue_valids", {sh_shift_valid, sh_input_valid}, 2'b11);
    chk("issue_shift", sh_shift_data, 7'd3);
    chk("issue_data", sh_input_data, 39'd1);
    chk("issue_last", sh_input_last, 1'b1);
    chk("issue_ready", {req0_ready, req1_ready}, 2'b10);
    drain(200);

    // Contention after reset: r0 first, packets kept whole.
    apply_reset(2);
    log_in.delete();
    src0.push_back('{1, 39'h10, 0}); src0.push_back('{1, 39'h11, 1});
    src1.push_back('{2, 39'h20, 0}); src1.push_back('{2, 39'h21, 1});
    drain(200);
    chk("cont_n", log_in.size(), 4);
    if (log_in.size() == 4) begin
      chk("cont_0", log_in[0], 39'h10);
      chk("cont_1", log_in[1], 39'h11);
      chk("cont_2", log_in[2], 39'h20);
      chk("cont_3", log_in[3], 39'h21);
    end
    log_in.delete();
    src0.push_back('{0, 39'h30, 1});
    src1.push_back('{0, 39'h40, 1});
    drain(200);
    chk("rr_n", log_in.size(), 2);
    if (log_in.size() == 2) begin
      chk("rr_first", log_in[0], 39'h30);
      chk("rr_second", log_in[1], 39'h40);
    end

    // Split acceptance: operand channel stalled for 3 cycles.
    pct_inr = 0;
    b = n_shhs;
    src0.push_back('{2, 5, 1});
    step();
    step();
    chk("split_shift_v", sh_shift_valid, 1'b1);
    chk("split_rdy_a", req0_ready, 1'b0);
    step();
    chk("split_shift_drop", sh_shift_valid, 1'b0);
    chk("split_in_v", sh_input_valid, 1'b1);
    chk("split_rdy_b", req0_ready, 1'b0);
    step();
    chk("split_rdy_c", req0_ready, 1'b0);
    chk("split_shift_once", n_shhs - b, 1);
    pct_inr = 100;
    step();
    chk("split_complete", req0_ready, 1'b1);
    step();
    chk("split_rdy_pulse", req0_ready, 1'b0);
    drain(200);

    // Tag FIFO full with result port blocked.
    pct_r0 = 0;
    b = n_inhs;
    for (int i = 0; i < 6; i++)
      src0.push_back('{SW'(i), IW'(i + 7), i == 5});
    repeat (30) step();
    chk("full_issued", n_inhs - b, TD);
    chk("full_valids", {sh_shift_valid, sh_input_valid}, 2'b00);
    pct_r0 = 100;
    drain(300);

    // Reset in the middle of a packet.
    pct_r0 = 0;
    b = n_inhs;
    for (int i = 0; i < 4; i++)
      src0.push_back('{1, IW'(i + 50), i == 3});
    for (int k = 0; k < 50 && (n_inhs - b) < 2; k++) step();
    chk("mid_issued", n_inhs - b, 2);
    apply_reset(2);
    pct_r0 = 100;
    b = n_r1;
    src1.push_back('{4, 39'h9, 0}); src1.push_back('{5, 39'hA, 1});
    drain(200);
    chk("post_reset_r1", n_r1 - b, 2);

    // Randomized traffic.
    apply_reset(2);
    pct_reqv = $urandom_range(100, 30); pct_shr = $urandom_range(100, 40);
    pct_inr = $urandom_range(100, 40);  pct_outv = $urandom_range(100, 40);
    pct_r0 = $urandom_range(100, 30);   pct_r1 = $urandom_range(100, 30);
    for (int i = 0; i < 40; i++) begin
      src0.push_back('{SW'($urandom_range(80)),
                      {7'($urandom), 32'($urandom)},
                      $urandom_range(2) == 0 || i == 39});
      src1.push_back('{SW'($urandom_range(80)),
                      {7'($urandom), 32'($urandom)},
                      $urandom_range(2) == 0 || i == 39});
    end
    drain(20000);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
